// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Pixel-strobe divider plus horizontal/vertical counters for a VGA raster
// (640x480@60 Hz by default). Downstream display logic aligns to col/row.
//
// Ports:
//   clk       in   FPGA clock
//   rst_n     in   asynchronous reset, active low
//   new_pxl   out  one-clock strobe in the last clock of each pixel period
//   col       out  current column, 0..h_total-1
//   row       out  current row, 0..v_total-1
//   visible   out  current (col,row) lies in the active area (registered)
//   hsync     out  horizontal sync, level c_synch_act when active (registered)
//   vsync     out  vertical sync, level c_synch_act when active (registered)
//   end_line  out  new_pxl on the last column of a line
//   end_frame out  end_line on the last row of a frame
module vga_sync_gen #(
  parameter logic c_synch_act = 1'b0,
  parameter int   c_pxl_div   = 4,
  parameter int   c_h_visible = 640,
  parameter int   c_h_fporch  = 16,
  parameter int   c_h_synch   = 96,
  parameter int   c_h_bporch  = 48,
  parameter int   c_v_visible = 480,
  parameter int   c_v_fporch  = 10,
  parameter int   c_v_synch   = 2,
  parameter int   c_v_bporch  = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       new_pxl,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic       end_line,
  output logic       end_frame
);

  localparam int c_h_total = c_h_visible + c_h_fporch + c_h_synch + c_h_bporch;
  localparam int c_v_total = c_v_visible + c_v_fporch + c_v_synch + c_v_bporch;

  localparam logic [9:0] c_pxl_last = 10'(c_pxl_div - 1);
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_vis    = 10'(c_h_visible);
  localparam logic [9:0] c_v_vis    = 10'(c_v_visible);
  localparam logic [9:0] c_hs_first = 10'(c_h_visible + c_h_fporch);
  localparam logic [9:0] c_hs_last  = 10'(c_h_visible + c_h_fporch + c_h_synch - 1);
  localparam logic [9:0] c_vs_first = 10'(c_v_visible + c_v_fporch);
  localparam logic [9:0] c_vs_last  = 10'(c_v_visible + c_v_fporch + c_v_synch - 1);

  logic [9:0] r_pxl_cnt;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       r_visible;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_new_pxl;
  logic       w_col_wrap;
  logic       w_row_wrap;
  logic [9:0] w_col_nxt;
  logic [9:0] w_row_nxt;
  logic       w_visible_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;

  // Next counter values and the flags that describe them; the flag registers
  // load these so they always match the col/row they sit beside.
  always_comb begin
    w_new_pxl  = (r_pxl_cnt == c_pxl_last);
    w_col_wrap = (r_col == c_h_last);
    w_row_wrap = (r_row == c_v_last);
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    if (w_col_wrap) begin
      w_col_nxt = 10'd0;
      if (w_row_wrap) begin
        w_row_nxt = 10'd0;
      end else begin
        w_row_nxt = r_row + 10'd1;
      end
    end else begin
      w_col_nxt = r_col + 10'd1;
    end
    w_visible_nxt = (w_col_nxt < c_h_vis) && (w_row_nxt < c_v_vis);
    if ((w_col_nxt >= c_hs_first) && (w_col_nxt <= c_hs_last)) begin
      w_hsync_nxt = c_synch_act;
    end else begin
      w_hsync_nxt = ~c_synch_act;
    end
    // vsync depends on the row only, so it flips at the column-0 edge
    if ((w_row_nxt >= c_vs_first) && (w_row_nxt <= c_vs_last)) begin
      w_vsync_nxt = c_synch_act;
    end else begin
      w_vsync_nxt = ~c_synch_act;
    end
  end

  // Pixel divider, raster counters and registered raster flags.
  // Reset parks the raster on the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pxl_cnt <= 10'd0;
      r_col     <= c_h_last;
      r_row     <= c_v_last;
      r_visible <= 1'b0;
      r_hsync   <= ~c_synch_act;
      r_vsync   <= ~c_synch_act;
    end else begin
      if (w_new_pxl) begin
        r_pxl_cnt <= 10'd0;
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_visible <= w_visible_nxt;
        r_hsync   <= w_hsync_nxt;
        r_vsync   <= w_vsync_nxt;
      end else begin
        r_pxl_cnt <= r_pxl_cnt + 10'd1;
      end
    end
  end

  assign new_pxl   = w_new_pxl;
  assign col       = r_col;
  assign row       = r_row;
  assign visible   = r_visible;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign end_line  = w_new_pxl && w_col_wrap;
  assign end_frame = w_new_pxl && w_col_wrap && w_row_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance (div 4) plus two small-raster
// instances (div 2 active-low syncs, div 1 active-high syncs) so that whole
// frames fit in a short run. Expected values come from a position model:
// after t clocks out of reset, t/div pixels have elapsed since the last pixel
// of the frame.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       np;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       el;
    logic       ef;
    logic [9:0] col;
    logic [9:0] row;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   t = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // clocks elapsed since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  logic       d0_np, d0_vis, d0_hs, d0_vs, d0_el, d0_ef;
  logic [9:0] d0_col, d0_row;
  logic       d1_np, d1_vis, d1_hs, d1_vs, d1_el, d1_ef;
  logic [9:0] d1_col, d1_row;
  logic       d2_np, d2_vis, d2_hs, d2_vs, d2_el, d2_ef;
  logic [9:0] d2_col, d2_row;

  vga_sync_gen d0 (
    .clk(clk), .rst_n(rst_n), .new_pxl(d0_np), .col(d0_col), .row(d0_row),
    .visible(d0_vis), .hsync(d0_hs), .vsync(d0_vs), .end_line(d0_el), .end_frame(d0_ef)
  );

  vga_sync_gen #(
    .c_synch_act(1'b0), .c_pxl_div(2),
    .c_h_visible(20), .c_h_fporch(3), .c_h_synch(5), .c_h_bporch(4),
    .c_v_visible(12), .c_v_fporch(2), .c_v_synch(2), .c_v_bporch(3)
  ) d1 (
    .clk(clk), .rst_n(rst_n), .new_pxl(d1_np), .col(d1_col), .row(d1_row),
    .visible(d1_vis), .hsync(d1_hs), .vsync(d1_vs), .end_line(d1_el), .end_frame(d1_ef)
  );

  vga_sync_gen #(
    .c_synch_act(1'b1), .c_pxl_div(1),
    .c_h_visible(20), .c_h_fporch(3), .c_h_synch(5), .c_h_bporch(4),
    .c_v_visible(12), .c_v_fporch(2), .c_v_synch(2), .c_v_bporch(3)
  ) d2 (
    .clk(clk), .rst_n(rst_n), .new_pxl(d2_np), .col(d2_col), .row(d2_row),
    .visible(d2_vis), .hsync(d2_hs), .vsync(d2_vs), .end_line(d2_el), .end_frame(d2_ef)
  );

  obs_t obs0, obs1, obs2;
  assign obs0 = {d0_np, d0_vis, d0_hs, d0_vs, d0_el, d0_ef, d0_col, d0_row};
  assign obs1 = {d1_np, d1_vis, d1_hs, d1_vs, d1_el, d1_ef, d1_col, d1_row};
  assign obs2 = {d2_np, d2_vis, d2_hs, d2_vs, d2_el, d2_ef, d2_col, d2_row};

  // reset images: raster parked on the last pixel, syncs inactive
  localparam obs_t RST0 = '{np: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, el: 1'b0, ef: 1'b0,
                            col: 10'd799, row: 10'd524};
  localparam obs_t RST1 = '{np: 1'b0, vis: 1'b0, hs: 1'b1, vs: 1'b1, el: 1'b0, ef: 1'b0,
                            col: 10'd31, row: 10'd18};
  localparam obs_t RST2 = '{np: 1'b1, vis: 1'b0, hs: 1'b0, vs: 1'b0, el: 1'b1, ef: 1'b1,
                            col: 10'd31, row: 10'd18};

  // Raster position after tt clocks: linear pixel index from the frame's last pixel.
  function automatic obs_t model(input int div, input int hv, input int hfp, input int hsw,
                                 input int hbp, input int vv, input int vfp, input int vsw,
                                 input int vbp, input logic act, input int tt);
    obs_t o;
    int htot, vtot, lin, c, r;
    htot  = hv + hfp + hsw + hbp;
    vtot  = vv + vfp + vsw + vbp;
    lin   = (htot * vtot - 1 + tt / div) % (htot * vtot);
    c     = lin % htot;
    r     = lin / htot;
    o.col = 10'(c);
    o.row = 10'(r);
    o.np  = ((tt % div) == (div - 1));
    o.vis = (c < hv) && (r < vv);
    o.hs  = ((c >= hv + hfp) && (c < hv + hfp + hsw)) ? act : ~act;
    o.vs  = ((r >= vv + vfp) && (r < vv + vfp + vsw)) ? act : ~act;
    o.el  = o.np && (c == htot - 1);
    o.ef  = o.el && (r == vtot - 1);
    return o;
  endfunction

  function automatic obs_t m0(input int tt);
    return model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, tt);
  endfunction
  function automatic obs_t m1(input int tt);
    return model(2, 20, 3, 5, 4, 12, 2, 2, 3, 1'b0, tt);
  endfunction
  function automatic obs_t m2(input int tt);
    return model(1, 20, 3, 5, 4, 12, 2, 2, 3, 1'b1, tt);
  endfunction

  task automatic test_reset();
    int first_np;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs0 !== RST0) begin
        errors++;
        $display("FAIL reset_hold t=%0d got=%h exp=%h", t, obs0, RST0);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    first_np = -1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (obs0.np && first_np < 0) first_np = t;
      checks++;
      if (obs0 !== m0(t)) begin
        errors++;
        $display("FAIL first_pixel t=%0d got=%h exp=%h", t, obs0, m0(t));
      end
    end
    checks++;
    if (first_np !== 3) begin
      errors++;
      $display("FAIL first_new_pxl got=%0d exp=3", first_np);
    end
    checks++;
    if (obs0.col !== 10'd0 || obs0.row !== 10'd0 || obs0.vis !== 1'b1) begin
      errors++;
      $display("FAIL origin col=%0d row=%0d vis=%b exp 0 0 1", obs0.col, obs0.row, obs0.vis);
    end
  endtask

  task automatic test_line();
    int vis_n, hs_n, el_n, el_col;
    vis_n = 0; hs_n = 0; el_n = 0; el_col = -1;
    repeat (3200) begin
      @(negedge clk);
      checks++;
      if (obs0 !== m0(t)) begin
        errors++;
        $display("FAIL line t=%0d got=%h exp=%h", t, obs0, m0(t));
      end
      if (obs0.np) begin
        if (obs0.vis) vis_n++;
        if (obs0.hs == 1'b0) hs_n++;
      end
      if (obs0.el) begin
        el_n++;
        el_col = int'(obs0.col);
      end
    end
    checks++;
    if (vis_n !== 640) begin errors++; $display("FAIL line_visible got=%0d exp=640", vis_n); end
    checks++;
    if (hs_n !== 96) begin errors++; $display("FAIL line_hsync got=%0d exp=96", hs_n); end
    checks++;
    if (el_n !== 1 || el_col !== 799) begin
      errors++;
      $display("FAIL line_end pulses=%0d col=%0d exp 1 at 799", el_n, el_col);
    end
  endtask

  task automatic test_frame();
    int nef1, last1, per1, vis1, vs1, nef2, last2, per_bad2, np_bad2;
    logic wrap_pend;
    nef1 = 0; last1 = 0; per1 = 0; vis1 = 0; vs1 = 0;
    nef2 = 0; last2 = 0; per_bad2 = 0; np_bad2 = 0; wrap_pend = 1'b0;
    repeat (2600) begin
      @(negedge clk);
      checks++;
      if (obs0 !== m0(t) || obs1 !== m1(t) || obs2 !== m2(t)) begin
        errors++;
        $display("FAIL frame t=%0d got=%h/%h/%h exp=%h/%h/%h",
                 t, obs0, obs1, obs2, m0(t), m1(t), m2(t));
      end
      if (wrap_pend) begin
        wrap_pend = 1'b0;
        checks++;
        if (obs1.col !== 10'd0 || obs1.row !== 10'd0 || obs1.vis !== 1'b1 ||
            obs1.hs !== 1'b1 || obs1.vs !== 1'b1) begin
          errors++;
          $display("FAIL wrap got=%h exp col=0 row=0 vis=1 syncs=1", obs1);
        end
      end
      if (obs1.np && nef1 == 1) begin
        if (obs1.vis) vis1++;
        if (obs1.vs == 1'b0) vs1++;
      end
      if (obs1.ef) begin
        checks++;
        if (obs1.el !== 1'b1) begin
          errors++;
          $display("FAIL wrap_end_line got=%b exp=1", obs1.el);
        end
        if (nef1 == 1) per1 = t - last1;
        last1 = t;
        nef1++;
        wrap_pend = 1'b1;
      end
      if (obs2.np !== 1'b1) np_bad2++;
      if (obs2.ef) begin
        if (nef2 > 0 && (t - last2) != 608) per_bad2++;
        last2 = t;
        nef2++;
      end
    end
    checks++;
    if (nef1 < 2 || per1 !== 1216) begin
      errors++;
      $display("FAIL frame_period pulses=%0d period=%0d exp 1216", nef1, per1);
    end
    checks++;
    if (vis1 !== 240) begin errors++; $display("FAIL frame_visible got=%0d exp=240", vis1); end
    checks++;
    if (vs1 !== 64) begin errors++; $display("FAIL frame_vsync got=%0d exp=64", vs1); end
    checks++;
    if (np_bad2 !== 0) begin errors++; $display("FAIL div1_new_pxl low_cycles=%0d exp=0", np_bad2); end
    checks++;
    if (nef2 < 4 || per_bad2 !== 0) begin
      errors++;
      $display("FAIL div1_frame pulses=%0d bad_periods=%0d exp 0", nef2, per_bad2);
    end
  endtask

  task automatic test_mid_reset();
    int run, hold;
    for (int k = 0; k < 3; k++) begin
      run  = $urandom_range(20, 900);
      hold = $urandom_range(1, 3);
      repeat (run) begin
        @(negedge clk);
        checks++;
        if (obs0 !== m0(t) || obs1 !== m1(t) || obs2 !== m2(t)) begin
          errors++;
          $display("FAIL pre_reset t=%0d got=%h/%h/%h", t, obs0, obs1, obs2);
        end
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs0 !== RST0 || obs1 !== RST1 || obs2 !== RST2) begin
        errors++;
        $display("FAIL async_reset got=%h/%h/%h exp=%h/%h/%h", obs0, obs1, obs2, RST0, RST1, RST2);
      end
      repeat (hold) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checks++;
        if (obs0 !== m0(t) || obs1 !== m1(t) || obs2 !== m2(t)) begin
          errors++;
          $display("FAIL restart t=%0d got=%h/%h/%h exp=%h/%h/%h",
                   t, obs0, obs1, obs2, m0(t), m1(t), m2(t));
        end
        if (t == 4) begin
          checks++;
          if (obs0.col !== 10'd0 || obs0.row !== 10'd0) begin
            errors++;
            $display("FAIL restart_origin col=%0d row=%0d exp 0 0", obs0.col, obs0.row);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
